// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit and receive blocks:
// the transmitter state encoding, the idle line level and a
// ceil(log2) helper used to size counters from parameters.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Smallest number of bits able to hold values 0..value-1.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-time divider shared by the UART transmitter and receiver.
// Counts clk cycles from 0 to CLKS_PER_BIT-1 and wraps; bit_end is
// high during the last cycle of each bit time. A synchronous clear
// holds the count at 0 so a new bit time starts cleanly.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int CNT_W = clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    // Free-running bit-time counter, wrapping at the end of each bit.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == LAST_COUNT) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign bit_end = (count == LAST_COUNT);

endmodule

// File: rtl/uart_tx.sv
// Parametrised UART transmitter. Accepts one word per send handshake
// while idle and shifts it out LSB first as start bit, DATA_W data
// bits, optional parity bit and STOP_BITS stop bits.
// Optional feature: define UART_TX_PARITY_EN to add the parity bit
// (PARITY_ODD selects odd sense, otherwise even).
// All outputs are registered one cycle behind the state register, so
// the line falls the cycle after accept and there is exactly one idle
// cycle between back-to-back frames.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              send,
    output logic              TXD,
    output logic              td_busy,
    output logic              tx_done
);

    localparam int IDX_W = clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] LAST_STOP_IDX = IDX_W'(STOP_BITS - 1);

    // Reject parameter values the frame logic cannot represent.
    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("uart_tx: DATA_W must be in 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx: CLKS_PER_BIT must be at least 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

    uart_tx_state_t    state;
    logic [DATA_W-1:0] shift;
    logic [IDX_W-1:0]  bit_idx;
    logic              bit_end;
    logic              cnt_clear;
`ifdef UART_TX_PARITY_EN
    logic              parity_bit;
`endif

    // The bit timer only runs while a frame is in progress.
    assign cnt_clear = (state == IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .bit_end(bit_end)
    );

    // Frame sequencer: state, shift register, bit index and registered line outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shift      <= '0;
            bit_idx    <= '0;
            TXD        <= UART_IDLE_LEVEL;
            td_busy    <= 1'b0;
            tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            td_busy <= (state != IDLE);
            case (state)
                IDLE: begin
                    TXD <= UART_IDLE_LEVEL;
                    if (send) begin
                        shift      <= tx_data;
                        bit_idx    <= '0;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= (^tx_data) ^ (PARITY_ODD != 0);
`endif
                        state      <= START;
                    end
                end
                START: begin
                    TXD <= ~UART_IDLE_LEVEL;
                    if (bit_end) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    TXD <= shift[0];
                    if (bit_end) begin
                        shift <= shift >> 1;
                        if (bit_idx == LAST_DATA_IDX) begin
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    TXD <= parity_bit;
                    if (bit_end) begin
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    TXD <= UART_IDLE_LEVEL;
                    if (bit_end) begin
                        if (bit_idx == LAST_STOP_IDX) begin
                            bit_idx <= '0;
                            tx_done <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    TXD   <= UART_IDLE_LEVEL;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx. Two instances: A (8 data bits, 1 stop bit,
// even parity sense) and B (7 data bits, 2 stop bits, odd parity
// sense). Stimulus pushes expected frames into per-instance queues;
// a negedge monitor pops a frame whenever td_busy rises and compares
// {TXD, td_busy, tx_done} every cycle against a frame model.
module tb_uart_tx;

    localparam int C      = 4;
    localparam int DW_A   = 8;
    localparam int STOP_A = 1;
    localparam int ODD_A  = 0;
    localparam int DW_B   = 7;
    localparam int STOP_B = 2;
    localparam int ODD_B  = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    typedef struct packed {
        logic [8:0] word;
        logic       b2b;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_a = '0;
    logic [6:0] data_b = '0;
    logic       send_a = 1'b0;
    logic       send_b = 1'b0;
    logic       txd_a, busy_a, done_a;
    logic       txd_b, busy_b, done_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    uart_tx #(
        .DATA_W(DW_A), .CLKS_PER_BIT(C), .STOP_BITS(STOP_A), .PARITY_ODD(ODD_A)
    ) dut_a (
        .clk(clk), .reset(reset), .tx_data(data_a), .send(send_a),
        .TXD(txd_a), .td_busy(busy_a), .tx_done(done_a)
    );

    uart_tx #(
        .DATA_W(DW_B), .CLKS_PER_BIT(C), .STOP_BITS(STOP_B), .PARITY_ODD(ODD_B)
    ) dut_b (
        .clk(clk), .reset(reset), .tx_data(data_b), .send(send_b),
        .TXD(txd_b), .td_busy(busy_b), .tx_done(done_b)
    );

    function automatic int frameLen(input int dw, input int stops);
        return (1 + dw + PAR + stops) * C;
    endfunction

    // Expected {TXD, td_busy, tx_done} in frame cycle k (k=0 is the first start-bit cycle).
    function automatic logic [2:0] expVec(input logic [8:0] word, input int dw,
                                          input int stops, input int odd, input int k);
        int   f;
        int   b;
        logic lvl;
        logic par;
        f = frameLen(dw, stops);
        if (k >= f) return 3'b100;
        b   = k / C;
        par = (odd != 0);
        for (int i = 0; i < dw; i++) par = par ^ word[i];
        if (b == 0)                       lvl = 1'b0;
        else if (b <= dw)                 lvl = word[b-1];
        else if (PAR == 1 && b == dw + 1) lvl = par;
        else                              lvl = 1'b1;
        return {lvl, 1'b1, (k == f - 1)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
        end
    endtask

    task automatic applyStimulus(input int d, input logic [8:0] word, input logic b2b);
        exp_t e;
        e.word = word;
        e.b2b  = b2b;
        @(posedge clk);
        #1;
        if (d == 0) begin
            data_a = word[7:0];
            send_a = 1'b1;
            q_a.push_back(e);
        end else begin
            data_b = word[6:0];
            send_b = 1'b1;
            q_b.push_back(e);
        end
        @(posedge clk);
        #1;
        send_a = 1'b0;
        send_b = 1'b0;
    endtask

    task automatic waitBusy(input int d, input logic level, input int maxc);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk);
            if (((d == 0) ? busy_a : busy_b) === level) ok = 1'b1;
        end
        checkOutput($sformatf("dut%0d wait busy=%0b", d, level), {31'd0, ok}, 32'd1);
    endtask

    task automatic runFrame(input int d, input logic [8:0] word);
        applyStimulus(d, word, 1'b0);
        waitBusy(d, 1'b1, 10);
        waitBusy(d, 1'b0, 100);
    endtask

    // Scoreboard monitor: pops expected frames as they start and checks every cycle.
    logic rstq = 1'b0;
    int   kpos[2];
    int   idle_run[2];
    logic in_frame[2];
    logic skip[2];
    exp_t cur[2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            kpos[d] = 0; idle_run[d] = 0; in_frame[d] = 1'b0; skip[d] = 1'b0;
            cur[d] = '0;
        end
    end

    always @(negedge clk) begin : monitor
        logic [2:0] act [2];
        int dw;
        int stops;
        int odd;
        act[0] = {txd_a, busy_a, done_a};
        act[1] = {txd_b, busy_b, done_b};
        for (int d = 0; d < 2; d++) begin
            dw    = (d == 0) ? DW_A   : DW_B;
            stops = (d == 0) ? STOP_A : STOP_B;
            odd   = (d == 0) ? ODD_A  : ODD_B;
            if (rstq) begin
                checkOutput($sformatf("dut%0d reset outputs", d), act[d], 3'b100);
                in_frame[d] = 1'b0;
                skip[d]     = 1'b0;
                idle_run[d] = 0;
            end else if (skip[d]) begin
                if (act[d][1] === 1'b0) skip[d] = 1'b0;
            end else if (in_frame[d]) begin
                checkOutput($sformatf("dut%0d frame %0h cycle %0d", d, cur[d].word, kpos[d]),
                            act[d], expVec(cur[d].word, dw, stops, odd, kpos[d]));
                kpos[d]++;
                if (kpos[d] == frameLen(dw, stops)) begin
                    in_frame[d] = 1'b0;
                    idle_run[d] = 0;
                end
            end else if (act[d][1] !== 1'b0) begin
                if ((d == 0 && q_a.size() == 0) || (d == 1 && q_b.size() == 0)) begin
                    checkOutput($sformatf("dut%0d busy with no frame queued", d), act[d][1], 1'b0);
                    skip[d] = 1'b1;
                end else begin
                    if (d == 0) cur[d] = q_a.pop_front();
                    else        cur[d] = q_b.pop_front();
                    if (cur[d].b2b)
                        checkOutput($sformatf("dut%0d idle gap", d), idle_run[d], 32'd1);
                    checkOutput($sformatf("dut%0d frame %0h cycle 0", d, cur[d].word),
                                act[d], expVec(cur[d].word, dw, stops, odd, 0));
                    kpos[d]     = 1;
                    in_frame[d] = 1'b1;
                end
            end else begin
                idle_run[d]++;
                checkOutput($sformatf("dut%0d idle", d), act[d], 3'b100);
            end
        end
        rstq = reset;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);

        // Basic frames on both instances
        runFrame(0, 9'h0A5);
        runFrame(1, 9'h07F);
        runFrame(1, 9'h025);

        // Data stability: tx_data toggles every cycle during the frame
        applyStimulus(0, 9'h03C, 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            data_a = ~data_a ^ i[7:0];
        end
        waitBusy(0, 1'b0, 100);

        // A send pulse mid-frame must not produce a second frame
        applyStimulus(0, 9'h081, 1'b0);
        waitBusy(0, 1'b1, 10);
        repeat (10) @(posedge clk);
        #1;
        data_a = 8'h55;
        send_a = 1'b1;
        @(posedge clk);
        #1;
        send_a = 1'b0;
        waitBusy(0, 1'b0, 100);
        repeat (10) @(posedge clk);

        // Back-to-back with send held high: 0x00 then 0xFF
        begin
            exp_t e0;
            exp_t e1;
            @(posedge clk);
            #1;
            e0.word = 9'h000; e0.b2b = 1'b0;
            data_a = 8'h00;
            send_a = 1'b1;
            q_a.push_back(e0);
            waitBusy(0, 1'b1, 10);
            @(posedge clk);
            #1;
            e1.word = 9'h0FF; e1.b2b = 1'b1;
            data_a = 8'hFF;
            q_a.push_back(e1);
            waitBusy(0, 1'b0, 100);
            waitBusy(0, 1'b1, 10);
            @(posedge clk);
            #1;
            send_a = 1'b0;
            waitBusy(0, 1'b0, 100);
        end
        repeat (3) @(posedge clk);

        // Reset during data bit 3, then a clean frame
        applyStimulus(0, 9'h0C3, 1'b0);
        waitBusy(0, 1'b1, 10);
        repeat (17) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        runFrame(0, 9'h0C3);

        repeat (5) @(posedge clk);
        checkOutput("dut0 frames left over", q_a.size(), 32'd0);
        checkOutput("dut1 frames left over", q_b.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
